// File: rtl/serial_half_subtractor_unit.sv
// rtl/serial_half_subtractor_unit.sv - bit-serial unsigned subtractor, diff = a - b, LSB first
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       operation request, honoured only while idle
//   a, b        minuend / subtrahend, captured when start is accepted
//   busy        high while bits are being processed
//   done        one-cycle pulse when diff / borrow_out have been updated
//   diff        (a - b) mod 2^WIDTH, held until the next completion or reset
//   borrow_out  1 iff a < b (unsigned)
module serial_half_subtractor_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] wr;
    logic [CW-1:0]    cnt;
    logic             br;

    // Single bit cell: operand LSBs plus the running borrow.
    logic             d0;
    logic             s0;
    logic             dbit;
    logic             br_next;
    logic [WIDTH-1:0] wr_next;

    always_comb begin
        d0      = sa[0];
        s0      = sb[0];
        dbit    = d0 ^ s0 ^ br;
        br_next = (~d0 & s0) | (~(d0 ^ s0) & br);
        // Result fills from the MSB end so after WIDTH shifts bit 0 sits at wr[0].
        wr_next = {dbit, wr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            wr         <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    wr  <= wr_next;
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    // Final bit: publish the result directly from the bit cell so
                    // diff never exposes a partially shifted value.
                    if (cnt == LAST_BIT) begin
                        diff       <= wr_next;
                        borrow_out <= br_next;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_half_subtractor_unit.sv
// tb/tb_serial_half_subtractor_unit.sv - self-checking bench for serial_half_subtractor_unit
module tb_serial_half_subtractor_unit;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start8;
    logic [W8-1:0] a8;
    logic [W8-1:0] b8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] diff8;
    logic          borrow8;

    logic          start4;
    logic [W4-1:0] a4;
    logic [W4-1:0] b4;
    logic          busy4;
    logic          done4;
    logic [W4-1:0] diff4;
    logic          borrow4;

    always #5 clk = ~clk;

    serial_half_subtractor_unit #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
    );

    serial_half_subtractor_unit #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       br;
    } exp8_t;

    typedef struct {
        logic [3:0] d;
        logic       br;
    } exp4_t;

    exp8_t q8[$];
    exp4_t q4[$];
    vec_t  tbl[$];

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] last_d;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboards: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("w8 unexpected done", 32'(done8), 32'd0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                check("w8 diff", 32'(diff8), 32'(e.d));
                check("w8 borrow", 32'(borrow8), 32'(e.br));
            end
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("w4 unexpected done", 32'(done4), 32'd0);
            end else begin
                exp4_t e;
                e = q4.pop_front();
                check("w4 diff", 32'(diff4), 32'(e.d));
                check("w4 borrow", 32'(borrow4), 32'(e.br));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(input int limit, output int cycles);
        cycles = 0;
        while (done8 !== 1'b1 && cycles < limit) begin
            tick();
            cycles++;
        end
        if (done8 !== 1'b1) check("w8 done timeout", 32'(done8), 32'd1);
    endtask

    // One isolated operation on the 8-bit unit with latency and handshake checks.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic br);
        int c;
        exp8_t e;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        e.d = d;
        e.br = br;
        q8.push_back(e);
        tick();
        start8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
        check("busy after start", 32'(busy8), 32'd1);
        check("diff held across start", 32'(diff8), 32'(last_d));
        wait_done8(W8 + 4, c);
        check("latency", 32'(c), 32'(W8));
        check("busy low at done", 32'(busy8), 32'd0);
        tick();
        check("done one cycle", 32'(done8), 32'd0);
        check("diff held after done", 32'(diff8), 32'(d));
        last_d = d;
    endtask

    initial begin
        int c;
        exp8_t e;
        exp4_t e4;

        tbl.push_back('{8'd5,   8'd3,   8'h02, 1'b0});
        tbl.push_back('{8'd3,   8'd5,   8'hFE, 1'b1});
        tbl.push_back('{8'h80,  8'h01,  8'h7F, 1'b0});
        tbl.push_back('{8'hFF,  8'hFF,  8'h00, 1'b0});
        tbl.push_back('{8'h00,  8'h00,  8'h00, 1'b0});
        tbl.push_back('{8'h00,  8'h01,  8'hFF, 1'b1});
        tbl.push_back('{8'hFF,  8'h00,  8'hFF, 1'b0});
        tbl.push_back('{8'h01,  8'hFF,  8'h02, 1'b1});
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            v.a = 8'($urandom_range(0, 255));
            v.b = 8'($urandom_range(0, 255));
            v.d = v.a - v.b;
            v.br = (v.a < v.b);
            tbl.push_back(v);
        end

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        last_d = 8'h00;
        tick();
        tick();
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        check("reset diff", 32'(diff8), 32'd0);
        check("reset borrow", 32'(borrow8), 32'd0);
        check("reset w4 busy", 32'(busy4), 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br);

        // Second request mid-run and operand changes are ignored.
        start8 = 1'b1; a8 = 8'd5; b8 = 8'd3;
        e.d = 8'h02; e.br = 1'b0;
        q8.push_back(e);
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd1;
        tick();
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
        tick();
        wait_done8(W8 + 4, c);
        check("latency with ignored start", 32'(c + 4), 32'(W8));
        for (int i = 0; i < W8 + 4; i++) tick();
        check("no extra op started", 32'(busy8), 32'd0);
        last_d = 8'h02;

        // Reset in the middle of RUN aborts without a done pulse.
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort done", 32'(done8), 32'd0);
        check("abort diff", 32'(diff8), 32'd0);
        check("abort borrow", 32'(borrow8), 32'd0);
        for (int i = 0; i < W8 + 4; i++) tick();
        check("abort stays idle", 32'(busy8), 32'd0);
        last_d = 8'h00;
        run_op(8'h22, 8'h11, 8'h11, 1'b0);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        e.d = 8'hF0; e.br = 1'b1;
        q8.push_back(e);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wait_done8(W8 + 4, c);
                check("held start first latency", 32'(c), 32'(W8));
            end else begin
                tick();
                wait_done8(W8 + 6, c);
                check("held start period", 32'(c + 1), 32'(W8 + 2));
            end
            if (i < 3) begin
                a8 = 8'(8'h31 * (i + 1));
                b8 = 8'(8'h47 + i * 8'h29);
                e.d = a8 - b8;
                e.br = (a8 < b8);
                q8.push_back(e);
            end else begin
                start8 = 1'b0;
            end
        end
        for (int i = 0; i < W8 + 4; i++) tick();

        // Exhaustive sweep on the 4-bit instance.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                start4 = 1'b1;
                a4 = 4'(x);
                b4 = 4'(y);
                e4.d = 4'(x - y);
                e4.br = (x < y);
                q4.push_back(e4);
                tick();
                start4 = 1'b0;
                c = 0;
                while (done4 !== 1'b1 && c < W4 + 4) begin
                    tick();
                    c++;
                end
                if (done4 !== 1'b1) check("w4 done timeout", 32'(done4), 32'd1);
                tick();
            end
        end
        tick();

        check("w8 scoreboard drained", 32'(q8.size()), 32'd0);
        check("w4 scoreboard drained", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
